vfb_cfg_seq: RTL and testbench

AXI4-Lite master sequencer that programs and stops the video frame-buffer read core at `BASE_ADDR`, replacing processor-driven register writes. It sits between the PL control logic and the frame-buffer's s_axi_CTRL slave. On `start` it writes the width, height, stride, format and plane-1 address registers, then control = 0x81 (ap_start | auto_restart). On `stop` it writes control = 0x00.

---
 rtl/vfb_cfg_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_vfb_cfg_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfb_cfg_seq.sv
// vfb_cfg_seq: AXI4-Lite master that programs and stops the frame-buffer read core.
// Optional macro VFB_CFG_POLL_EN adds an ap_idle status poll after the stop write.
module vfb_cfg_seq #(
    parameter logic [31:0] BASE_ADDR   = 32'h43C0_0000,
    parameter int          PIXEL_BYTES = 4,
    parameter int          TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_height,
    input  logic [15:0] cfg_stride,
    input  logic [7:0]  cfg_format,
    input  logic [31:0] cfg_plane1,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WRESP = 3'd2,
        S_NEXT  = 3'd3,
        S_RADDR = 3'd4,
        S_RDATA = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [2:0]     LAST_STEP = 3'd5;
    localparam logic [31:0]    PB        = 32'(PIXEL_BYTES);

    // Register offset for each write step; step 5 is the control register.
    function automatic logic [31:0] step_offset(input logic [2:0] step);
        logic [31:0] off;
        case (step)
            3'd0:    off = 32'h0000_0010;
            3'd1:    off = 32'h0000_0018;
            3'd2:    off = 32'h0000_0020;
            3'd3:    off = 32'h0000_0028;
            3'd4:    off = 32'h0000_0030;
            default: off = 32'h0000_0000;
        endcase
        return off;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_step;
    logic [2:0]    w_step_nxt;
    logic          r_is_stop;
    logic          w_is_stop_nxt;
    logic [15:0]   r_width,  w_width_nxt;
    logic [15:0]   r_height, w_height_nxt;
    logic [31:0]   r_stride, w_stride_nxt;
    logic [7:0]    r_format, w_format_nxt;
    logic [31:0]   r_plane1, w_plane1_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic          w_accept;
    logic          w_tmo;
    logic          w_aw_ok;
    logic          w_w_ok;
    logic          w_enter_waddr;
    logic [31:0]   w_sel_data;

    logic          r_busy,    w_busy_nxt;
    logic          r_done,    w_done_nxt;
    logic          r_err,     w_err_nxt;
    logic [31:0]   r_awaddr,  w_awaddr_nxt;
    logic          r_awvalid, w_awvalid_nxt;
    logic [31:0]   r_wdata,   w_wdata_nxt;
    logic          r_wvalid,  w_wvalid_nxt;
    logic          r_bready,  w_bready_nxt;

    assign w_accept = (r_state == S_IDLE) && (start || stop);
    assign w_tmo    = (r_tmo_cnt == TMO_LAST);
    // A channel is satisfied once its valid has dropped or is being accepted now.
    assign w_aw_ok  = !r_awvalid || m_awready;
    assign w_w_ok   = !r_wvalid  || m_wready;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WADDR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WADDR: begin
                if (w_aw_ok && w_w_ok) begin
                    w_state_nxt = S_WRESP;
                end else if (w_tmo) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_WADDR;
                end
            end
            S_WRESP: begin
                if (m_bvalid) begin
                    w_state_nxt = (m_bresp == 2'b00) ? S_NEXT : S_ERR;
                end else if (w_tmo) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_WRESP;
                end
            end
            S_NEXT: begin
                if (r_step != LAST_STEP) begin
                    w_state_nxt = S_WADDR;
                end else if (r_is_stop) begin
`ifdef VFB_CFG_POLL_EN
                    w_state_nxt = S_RADDR;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
`ifdef VFB_CFG_POLL_EN
            S_RADDR: begin
                if (m_arready) begin
                    w_state_nxt = S_RDATA;
                end else if (w_tmo) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_RADDR;
                end
            end
            S_RDATA: begin
                if (m_rvalid) begin
                    if (m_rresp != 2'b00) begin
                        w_state_nxt = S_ERR;
                    end else if (m_rdata[2]) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RADDR;
                    end
                end else if (w_tmo) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_RDATA;
                end
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shadow copies of the configuration and the step index; stop jumps straight to the control write.
    always_comb begin
        w_width_nxt   = r_width;
        w_height_nxt  = r_height;
        w_stride_nxt  = r_stride;
        w_format_nxt  = r_format;
        w_plane1_nxt  = r_plane1;
        w_step_nxt    = r_step;
        w_is_stop_nxt = r_is_stop;
        if (w_accept) begin
            w_width_nxt   = cfg_width;
            w_height_nxt  = cfg_height;
            w_stride_nxt  = (cfg_stride == 16'h0000) ? ({16'h0000, cfg_width} * PB)
                                                     : {16'h0000, cfg_stride};
            w_format_nxt  = cfg_format;
            w_plane1_nxt  = cfg_plane1;
            w_step_nxt    = start ? 3'd0 : LAST_STEP;
            w_is_stop_nxt = !start;
        end else if ((r_state == S_NEXT) && (r_step != LAST_STEP)) begin
            w_step_nxt = r_step + 3'd1;
        end else begin
            w_step_nxt = r_step;
        end
    end

    // Write data for the step about to be issued.
    always_comb begin
        w_sel_data = 32'h0000_0000;
        case (w_step_nxt)
            3'd0:    w_sel_data = {16'h0000, w_width_nxt};
            3'd1:    w_sel_data = {16'h0000, w_height_nxt};
            3'd2:    w_sel_data = w_stride_nxt;
            3'd3:    w_sel_data = {24'h00_0000, w_format_nxt};
            3'd4:    w_sel_data = w_plane1_nxt;
            3'd5:    w_sel_data = w_is_stop_nxt ? 32'h0000_0000 : 32'h0000_0081;
            default: w_sel_data = 32'h0000_0000;
        endcase
    end

    // Shadow, step and handshake timeout registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_width   <= 16'h0000;
            r_height  <= 16'h0000;
            r_stride  <= 32'h0000_0000;
            r_format  <= 8'h00;
            r_plane1  <= 32'h0000_0000;
            r_step    <= 3'd0;
            r_is_stop <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_width   <= w_width_nxt;
            r_height  <= w_height_nxt;
            r_stride  <= w_stride_nxt;
            r_format  <= w_format_nxt;
            r_plane1  <= w_plane1_nxt;
            r_step    <= w_step_nxt;
            r_is_stop <= w_is_stop_nxt;
            if (w_state_nxt != r_state) begin
                r_tmo_cnt <= '0;
            end else if (!w_tmo) begin
                r_tmo_cnt <= r_tmo_cnt + {{(TW-1){1'b0}}, 1'b1};
            end else begin
                r_tmo_cnt <= r_tmo_cnt;
            end
        end
    end

    assign w_enter_waddr = (w_state_nxt == S_WADDR) && (r_state != S_WADDR);

    // Output logic, evaluated against the next state so every port is a flop.
    always_comb begin
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        if (w_enter_waddr) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_awaddr_nxt  = BASE_ADDR + step_offset(w_step_nxt);
            w_wdata_nxt   = w_sel_data;
        end else if ((r_state == S_WADDR) && (w_state_nxt == S_WADDR)) begin
            w_awvalid_nxt = r_awvalid && !m_awready;
            w_wvalid_nxt  = r_wvalid && !m_wready;
        end else begin
            w_awvalid_nxt = 1'b0;
            w_wvalid_nxt  = 1'b0;
        end
        w_bready_nxt = (w_state_nxt == S_WRESP);
        w_done_nxt   = (w_state_nxt == S_DONE);
        w_busy_nxt   = w_state_nxt inside {S_WADDR, S_WRESP, S_NEXT, S_RADDR, S_RDATA};
        if (w_state_nxt == S_ERR) begin
            w_err_nxt = 1'b1;
        end else if (w_accept) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_awaddr  <= 32'h0000_0000;
            r_awvalid <= 1'b0;
            r_wdata   <= 32'h0000_0000;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign m_awaddr  = r_awaddr;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = 4'hF;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;

`ifdef VFB_CFG_POLL_EN
    logic [31:0] r_araddr;
    logic        r_arvalid;
    logic        r_rready;
    logic        w_unused_rdata;

    assign w_unused_rdata = ^{m_rdata[31:3], m_rdata[1:0]};

    // Status-poll read channel registers; the poll always targets the control register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_araddr  <= 32'h0000_0000;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            r_araddr  <= (w_state_nxt == S_RADDR) ? BASE_ADDR : r_araddr;
            r_arvalid <= (w_state_nxt == S_RADDR);
            r_rready  <= (w_state_nxt == S_RDATA);
        end
    end

    assign m_araddr  = r_araddr;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;
`else
    logic w_unused_rd;

    assign w_unused_rd = ^{m_arready, m_rdata, m_rresp, m_rvalid};
    assign m_araddr    = 32'h0000_0000;
    assign m_arvalid   = 1'b0;
    assign m_rready    = 1'b0;
`endif

endmodule

// File: tb/tb_vfb_cfg_seq.sv
// Self-checking bench for vfb_cfg_seq: AXI-Lite slave model with a write scoreboard.
module tb_vfb_cfg_seq;

    localparam logic [31:0] BASE = 32'h43C0_0000;
    localparam int          TMO  = 1024;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] cfg_width = 16'h0, cfg_height = 16'h0, cfg_stride = 16'h0;
    logic [7:0]  cfg_format = 8'h0;
    logic [31:0] cfg_plane1 = 32'h0;
    logic        busy, done, err;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    vfb_cfg_seq #(.BASE_ADDR(BASE), .PIXEL_BYTES(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
        .cfg_format(cfg_format), .cfg_plane1(cfg_plane1),
        .busy(busy), .done(done), .err(err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          aw_lat = 0, w_lat = 0;
    bit          no_b = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          rd_base = 0;

    // slave-owned state
    int          aw_wait = 0, w_wait = 0, aw_count = 0, rd_count = 0;
    logic        got_aw = 1'b0, got_w = 1'b0;
    logic [31:0] aw_addr_q = 32'h0, w_data_q = 32'h0;
    logic        aw_hs, w_hs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_compare(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("wr_addr", a, e.addr);
            check_eq("wr_data", d, e.data);
        end
        check_eq("wr_strb", 32'(m_wstrb), 32'h0000_000F);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    assign m_awready = m_awvalid && (aw_wait >= aw_lat);
    assign m_wready  = m_wvalid && (w_wait >= w_lat);
    assign m_arready = m_arvalid;
    assign aw_hs     = m_awvalid && m_awready;
    assign w_hs      = m_wvalid && m_wready;
    assign m_rresp   = 2'b00;

    // AXI-Lite slave: configurable ready latency, error injection by address, status poll data
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            got_aw   <= 1'b0;
            got_w    <= 1'b0;
            aw_wait  <= 0;
            w_wait   <= 0;
            m_bvalid <= 1'b0;
            m_bresp  <= 2'b00;
            m_rvalid <= 1'b0;
            m_rdata  <= 32'h0;
        end else begin
            aw_wait <= (m_awvalid && !aw_hs) ? aw_wait + 1 : 0;
            w_wait  <= (m_wvalid && !w_hs) ? w_wait + 1 : 0;
            if (aw_hs) begin
                check_eq("dup_aw", 32'(got_aw), 32'd0);
                aw_addr_q <= m_awaddr;
                got_aw    <= 1'b1;
                aw_count  <= aw_count + 1;
            end
            if (w_hs) begin
                check_eq("dup_w", 32'(got_w), 32'd0);
                w_data_q <= m_wdata;
                got_w    <= 1'b1;
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                sb_compare(aw_hs ? m_awaddr : aw_addr_q, w_hs ? m_wdata : w_data_q);
                got_aw   <= 1'b0;
                got_w    <= 1'b0;
                m_bvalid <= !no_b;
                m_bresp  <= ((aw_hs ? m_awaddr : aw_addr_q) == err_addr) ? 2'b10 : 2'b00;
            end
            if (m_arvalid && m_arready) begin
                check_eq("rd_addr", m_araddr, BASE);
                m_rvalid <= 1'b1;
                m_rdata  <= ((rd_count - rd_base) >= 2) ? 32'h0000_0004 : 32'h0000_0000;
                rd_count <= rd_count + 1;
            end else if (m_rvalid && m_rready) begin
                m_rvalid <= 1'b0;
            end
        end
    end

    task automatic push_start(input logic [15:0] w, h, s, input logic [7:0] f, input logic [31:0] p);
        logic [31:0] stride;
        stride = (s == 16'h0) ? (32'(w) * 32'd4) : 32'(s);
        exp_q.push_back('{BASE + 32'h10, 32'(w)});
        exp_q.push_back('{BASE + 32'h18, 32'(h)});
        exp_q.push_back('{BASE + 32'h20, stride});
        exp_q.push_back('{BASE + 32'h28, 32'(f)});
        exp_q.push_back('{BASE + 32'h30, p});
        exp_q.push_back('{BASE + 32'h00, 32'h0000_0081});
    endtask

    task automatic pulse(input logic [15:0] w, h, s, input logic [7:0] f, input logic [31:0] p,
                         input logic do_start, input logic do_stop);
        @(negedge clk);
        cfg_width = w; cfg_height = h; cfg_stride = s; cfg_format = f; cfg_plane1 = p;
        start = do_start; stop = do_stop;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0; stop = 1'b0;
        cfg_width = 16'($urandom); cfg_height = 16'($urandom); cfg_stride = 16'($urandom);
        cfg_format = 8'($urandom); cfg_plane1 = $urandom;
    endtask

    task automatic wait_end(input int bound, output int lat, output bit got_done, output bit got_err);
        got_done = 1'b0; got_err = 1'b0; lat = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin got_done = 1'b1; lat = cyc - t0; break; end
            if (err)  begin got_err = 1'b1;  lat = cyc - t0; break; end
        end
    endtask

    initial begin
        int lat, n, cnt0;
        bit gd, ge, found;

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("rst_awvalid", 32'(m_awvalid), 32'd0);
        check_eq("rst_wvalid", 32'(m_wvalid), 32'd0);
        check_eq("rst_bready", 32'(m_bready), 32'd0);
        check_eq("rst_flags", {29'd0, busy, done, err}, 32'd0);
        check_eq("rst_awaddr", m_awaddr, 32'd0);
        check_eq("rst_wdata", m_wdata, 32'd0);
        check_eq("rst_wstrb", 32'(m_wstrb), 32'h0000_000F);
        check_eq("rst_rd", {m_araddr[30:0], m_arvalid | m_rready}, 32'd0);

        // zero-wait slave, reference sequence
        push_start(16'd640, 16'd480, 16'd0, 8'd20, 32'h0010_0000);
        pulse(16'd640, 16'd480, 16'd0, 8'd20, 32'h0010_0000, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("busy_rise", 32'(busy), 32'd1);
        wait_end(100, lat, gd, ge);
        check_eq("zw_done", 32'(gd), 32'd1);
        check_eq("zw_latency", 32'(lat), 32'd18);
        check_eq("zw_busy_at_done", 32'(busy), 32'd0);
        check_eq("zw_sb_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done), 32'd0);

        // awready 3 cycles ahead of wready
        aw_lat = 0; w_lat = 3;
        push_start(16'd640, 16'd480, 16'd0, 8'd20, 32'h0010_0000);
        pulse(16'd640, 16'd480, 16'd0, 8'd20, 32'h0010_0000, 1'b1, 1'b0);
        wait_end(300, lat, gd, ge);
        check_eq("skew_done", 32'(gd), 32'd1);
        check_eq("skew_latency", 32'(lat), 32'd36);
        check_eq("skew_sb_empty", 32'(exp_q.size()), 32'd0);

        // wready ahead of awready, explicit stride
        aw_lat = 2; w_lat = 0;
        push_start(16'd1920, 16'd1080, 16'd8192, 8'd29, 32'h2000_0000);
        pulse(16'd1920, 16'd1080, 16'd8192, 8'd29, 32'h2000_0000, 1'b1, 1'b0);
        wait_end(300, lat, gd, ge);
        check_eq("skew2_done", 32'(gd), 32'd1);
        check_eq("skew2_sb_empty", 32'(exp_q.size()), 32'd0);
        aw_lat = 0; w_lat = 0;

        // SLVERR on the height write
        err_addr = BASE + 32'h18;
        push_start(16'd640, 16'd480, 16'd0, 8'd20, 32'h0010_0000);
        pulse(16'd640, 16'd480, 16'd0, 8'd20, 32'h0010_0000, 1'b1, 1'b0);
        wait_end(100, lat, gd, ge);
        check_eq("slverr_err", 32'(ge), 32'd1);
        check_eq("slverr_busy", 32'(busy), 32'd0);
        check_eq("slverr_remaining", 32'(exp_q.size()), 32'd4);
        exp_q.delete();
        cnt0 = aw_count;
        repeat (20) @(negedge clk);
        check_eq("slverr_no_aw", 32'(aw_count - cnt0), 32'd0);
        check_eq("err_sticky", 32'(err), 32'd1);
        err_addr = 32'hFFFF_FFFF;
        push_start(16'd800, 16'd600, 16'd0, 8'd7, 32'h0300_0000);
        pulse(16'd800, 16'd600, 16'd0, 8'd7, 32'h0300_0000, 1'b1, 1'b0);
        check_eq("err_cleared", 32'(err), 32'd0);
        wait_end(100, lat, gd, ge);
        check_eq("recover_done", 32'(gd), 32'd1);
        check_eq("recover_sb_empty", 32'(exp_q.size()), 32'd0);

        // bvalid never arrives
        no_b = 1'b1;
        push_start(16'd640, 16'd480, 16'd0, 8'd20, 32'h0010_0000);
        pulse(16'd640, 16'd480, 16'd0, 8'd20, 32'h0010_0000, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_bready) begin found = 1'b1; break; end
        end
        check_eq("tmo_bready_seen", 32'(found), 32'd1);
        n = 1;
        for (int i = 0; i < TMO + 100; i++) begin
            @(negedge clk);
            if (!m_bready) break;
            n++;
        end
        check_eq("tmo_cycles", 32'(n), 32'(TMO));
        check_eq("tmo_err", 32'(err), 32'd1);
        check_eq("tmo_busy", 32'(busy), 32'd0);
        exp_q.delete();
        no_b = 1'b0;

        // stop sequence
        rd_base = rd_count;
        exp_q.push_back('{BASE, 32'h0000_0000});
        pulse(16'd1, 16'd1, 16'd1, 8'd1, 32'h1, 1'b0, 1'b1);
        wait_end(200, lat, gd, ge);
        check_eq("stop_done", 32'(gd), 32'd1);
        check_eq("stop_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef VFB_CFG_POLL_EN
        check_eq("stop_reads", 32'(rd_count - rd_base), 32'd3);
        check_eq("stop_latency", 32'(lat), 32'd9);
`else
        check_eq("stop_reads", 32'(rd_count - rd_base), 32'd0);
        check_eq("stop_latency", 32'(lat), 32'd3);
`endif

        // start and stop together: start wins
        push_start(16'd320, 16'd240, 16'd0, 8'd3, 32'h0040_0000);
        pulse(16'd320, 16'd240, 16'd0, 8'd3, 32'h0040_0000, 1'b1, 1'b1);
        wait_end(100, lat, gd, ge);
        check_eq("both_done", 32'(gd), 32'd1);
        check_eq("both_latency", 32'(lat), 32'd18);
        check_eq("both_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset while waiting in WADDR
        aw_lat = 100; w_lat = 100;
        cnt0 = aw_count;
        pulse(16'd640, 16'd480, 16'd0, 8'd20, 32'h0010_0000, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_awvalid", 32'(m_awvalid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check_eq("rst_mid_valids", {30'd0, m_awvalid, m_wvalid}, 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        aw_lat = 0; w_lat = 0;
        repeat (10) @(negedge clk);
        check_eq("post_rst_idle", {30'd0, busy, m_awvalid}, 32'd0);
        check_eq("post_rst_no_aw", 32'(aw_count - cnt0), 32'd0);

        // widest line with default stride: no truncation of width*4
        push_start(16'hFFFF, 16'd2, 16'd0, 8'hFF, 32'hFFFF_FFF0);
        pulse(16'hFFFF, 16'd2, 16'd0, 8'hFF, 32'hFFFF_FFF0, 1'b1, 1'b0);
        wait_end(100, lat, gd, ge);
        check_eq("wide_done", 32'(gd), 32'd1);
        check_eq("wide_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
